scic_io_sequencer: RTL and testbench
====================================

// Module: scic_io_sequencer
// PURPOSE
//   Synthesizable on-chip stimulus/check engine for the SCIC switch/LED I/O path.
//   Steps the SCIC switch inputs through a selectable pattern set (count, walking-one, LFSR).
//   Holds each pattern for a programmable number of clocks, samples the LEDs at the end of
//   each hold, and counts LED/switch mismatches for echo-style programs. Sits between board
//   I/O and the SCIC core, so the read/write-IO test runs at speed without a host.
// PARAMETERS
//   WIDTH      4     switch/LED bus width (>=2, <=16)
//   HOLD_W     8     width of hold_cycles
//   ERR_W      8     width of err_count (saturating)
//   LFSR_SEED  1     LFSR start value; must be non-zero, WIDTH bits
// PORTS
//   clock        in   1        system clock; all logic on rising edge
//   reset        in   1        synchronous, active-high
//   start        in   1        run request; accepted only in IDLE or DONE
//   mode         in   2        0=count, 1=walking-one, 2=LFSR, 3=reserved (treated as count)
//   hold_cycles  in   HOLD_W   clocks each pattern is held; 0 treated as 1
//   check_en     in   1        1=compare leds against switches at each sample
//   switches     out  WIDTH    pattern driven to SCIC switch inputs
//   leds         in   WIDTH    SCIC LED outputs, same clock domain
//   busy         out  1        high while RUN
//   done         out  1        sticky high in DONE until next accepted start or reset
//   err_count    out  ERR_W    mismatch count, saturates at all-ones
//   pass         out  1        done && err_count==0
// BEHAVIOUR
//   - Reset: state IDLE; switches=0, busy=0, done=0, err_count=0, pass=0. Reset mid-run aborts
//     immediately: no sample taken, no further pattern driven.
//   - States: IDLE -start-> RUN; RUN -last sample-> DONE; DONE -start-> RUN. No other transitions.
//   - On an accepted start edge, latch mode, hold_cycles (0->1) and check_en. Clear err_count
//     and done. Load the first pattern: switches is valid the cycle after the start edge.
//   - start while RUN is ignored. mode/hold_cycles/check_en changes mid-run are ignored.
//   - Each step lasts exactly H = latched hold clocks. Hold counter loads H-1 and decrements.
//     On the cycle where the counter is 0 (the last cycle of the step):
//     sample leds, compare with the current switches, and advance the pattern on that edge.
//   - Mismatch (check_en=1 and leds != switches): err_count += 1 unless already all-ones.
//   - Patterns, with step count N:
//       count: 1,2,...,2^WIDTH-1; N = 2^WIDTH-1
//       walk:  1<<0 .. 1<<(WIDTH-1); N = WIDTH
//       LFSR:  Galois max-length from LFSR_SEED; N = 2^WIDTH-1; each non-zero value exactly once
//   - After the sample of step N: go to DONE, switches=0, busy=0, done=1.
//     done rises N*H cycles after the start edge. The last error increment is visible
//     together with done.
//   - busy=1 from the cycle after the start edge through the last step's sample cycle.
//   - pass is combinational from registered done/err_count (no extra latency).
// STRUCTURE
//   - Package scic_io_pkg: state enum {IDLE,RUN,DONE}; mode constants MODE_COUNT/WALK/LFSR;
//     function lfsr_taps(width) returning the max-length tap mask for widths 2..16;
//     function num_steps(mode,width).
//   - Sub-module scic_pattern_gen (WIDTH, LFSR_SEED):
//     inputs load/advance/mode; outputs pattern and last (current pattern is step N).
//   - Top level holds the FSM, hold counter, comparator and saturating error counter.
// TESTING
//   1. Loopback leds=switches, count mode, hold=6, check_en=1, start pulse -> switches
//      steps 1..15, each for 6 clocks; done at +90; err_count=0; pass=1.
//   2. Walk mode, leds=switches&4'b1110, hold=3 -> patterns 1,2,4,8; done at +12;
//      err_count=1; pass=0. Count mode with the same fault -> err_count=8.
//   3. LFSR mode, hold=1 -> 15 consecutive distinct non-zero values starting 4'h1;
//      done at +15; scoreboard sees every value 1..15 once.
//   4. ERR_W=2, leds tied 0, count mode -> err_count saturates at 3; pass=0.
//      hold=0 behaves as hold=1 (done at +15).
//   5. Reset asserted at cycle 20 of a count run -> next cycle switches=0, busy=0, done=0,
//      err_count=0. start pulsed during RUN -> ignored; step timing unchanged.
//   6. start in DONE -> err_count clears, done drops the next cycle, and the run repeats
//      with identical timing. check_en=0 with faulty leds -> err_count=0, pass=1.

Source files
------------

// File: rtl/scic_io_sequencer_pkg.sv
// Shared types and helpers for the SCIC I/O sequencer: FSM state encoding,
// pattern-mode codes, LFSR tap table and per-mode step count.
package scic_io_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_COUNT = 2'd0;
   localparam logic [1:0] MODE_WALK  = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   // Mode 3 is reserved and behaves exactly like MODE_COUNT.

   // Galois (right-shift) tap masks giving a maximal-length sequence.
   // Bit i set means "XOR into bit i when the shifted-out bit is 1".
   function automatic logic [15:0] lfsr_taps(input int width);
      logic [15:0] taps;
      case (width)
         2:       taps = 16'h0003;
         3:       taps = 16'h0006;
         4:       taps = 16'h000C;
         5:       taps = 16'h0014;
         6:       taps = 16'h0030;
         7:       taps = 16'h0060;
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0E08;
         13:      taps = 16'h1C80;
         14:      taps = 16'h3802;
         15:      taps = 16'h6000;
         16:      taps = 16'hD008;
         default: taps = 16'h0003;
      endcase
      return taps;
   endfunction

   // Number of distinct patterns a run steps through for a given mode.
   function automatic int num_steps(input logic [1:0] mode, input int width);
      if (mode == MODE_WALK)
         return width;
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/scic_io_sequencer_if.sv
// Board/host-facing bundle of the SCIC I/O sequencer.
// Handshake: start is a level sampled on every rising clock edge and is
// accepted only while busy is low (idle or done); mode, hold_cycles and
// check_en are captured on that same edge and ignored afterwards. busy stays
// high until the last sample; done then stays high until the next accepted
// start or reset. leds is sampled on the last cycle of each pattern hold.
interface scic_io_sequencer_if #(
   parameter int WIDTH  = 4,
   parameter int HOLD_W = 8,
   parameter int ERR_W  = 8
) ();
   import scic_io_pkg::*;

   logic              start;
   logic [1:0]        mode;
   logic [HOLD_W-1:0] hold_cycles;
   logic              check_en;
   logic [WIDTH-1:0]  leds;
   logic [WIDTH-1:0]  switches;
   logic              busy;
   logic              done;
   logic [ERR_W-1:0]  err_count;
   logic              pass;
   state_t            state;

   // Host / board side: issues runs and returns the LED values.
   modport master (
      output start, mode, hold_cycles, check_en, leds,
      input  switches, busy, done, err_count, pass, state
   );

   // Sequencer side.
   modport slave (
      input  start, mode, hold_cycles, check_en, leds,
      output switches, busy, done, err_count, pass, state
   );

endinterface

// File: rtl/scic_io_sequencer_pattern_gen.sv
// Pattern generator: produces the count / walking-one / LFSR sequence and
// flags the final step of the run. The mode is captured on load so that
// input changes mid-run cannot disturb the sequence.
module scic_pattern_gen
   import scic_io_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LFSR_SEED = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] pattern,
   output logic             last
);

   localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED     = WIDTH'(LFSR_SEED);

   logic [1:0]       mode_q;
   logic [WIDTH-1:0] pat_q;
   logic [WIDTH-1:0] pat_nxt;
   logic [WIDTH-1:0] pat_first;
   logic [WIDTH-1:0] step_q;

   // First pattern of a run depends on the mode being requested at load.
   always_comb begin
      pat_first = WIDTH'(1);
      if (mode == MODE_LFSR)
         pat_first = SEED;
   end

   // Successor of the current pattern in the latched mode.
   always_comb begin
      pat_nxt = pat_q + 1'b1;
      case (mode_q)
         MODE_WALK: pat_nxt = pat_q << 1;
         MODE_LFSR: pat_nxt = (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);
         default:   ;
      endcase
   end

   // Pattern, step index and mode registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q <= MODE_COUNT;
         pat_q  <= '0;
         step_q <= '0;
      end else if (load) begin
         mode_q <= mode;
         pat_q  <= pat_first;
         step_q <= '0;
      end else if (advance) begin
         pat_q  <= pat_nxt;
         step_q <= step_q + 1'b1;
      end
   end

   assign pattern = pat_q;
   // A step index is kept rather than decoding the pattern so that the LFSR
   // end point does not depend on which seed was chosen.
   assign last    = (int'(step_q) == num_steps(mode_q, WIDTH) - 1);

endmodule

// File: rtl/scic_io_sequencer.sv
// SCIC I/O sequencer top: run FSM, per-step hold counter, LED/switch
// comparator and saturating mismatch counter around the pattern generator.
module scic_io_sequencer
   import scic_io_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int HOLD_W    = 8,
   parameter int ERR_W     = 8,
   parameter int LFSR_SEED = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   scic_io_sequencer_if.slave   io
);

   state_t            state;
   state_t            state_nxt;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_eff;
   logic              check_q;
   logic [ERR_W-1:0]  err_q;
   logic [WIDTH-1:0]  pattern;
   logic              last;
   logic              accept;
   logic              sample;
   logic              advance;
   logic              mismatch;

   // A hold of zero would never reach a sample point, so it runs as one.
   assign hold_eff = (io.hold_cycles == '0) ? HOLD_W'(1) : io.hold_cycles;
   assign accept   = io.start && (state != RUN);
   // Counter at zero marks the last cycle of a step: sample and move on.
   assign sample   = (state == RUN) && (hold_cnt == '0);
   assign advance  = sample && !last;
   assign mismatch = sample && check_q && (io.leds != pattern);

   scic_pattern_gen #(
      .WIDTH     (WIDTH),
      .LFSR_SEED (LFSR_SEED)
   ) u_pattern_gen (
      .clock   (clock),
      .reset   (reset),
      .load    (accept),
      .advance (advance),
      .mode    (io.mode),
      .pattern (pattern),
      .last    (last)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next-state: start leaves IDLE/DONE, the final sample ends RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.start) state_nxt = RUN;
         RUN:     if (sample && last) state_nxt = DONE;
         DONE:    if (io.start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: everything is decoded from registered state/counters.
   always_comb begin
      io.switches  = (state == RUN) ? pattern : '0;
      io.busy      = (state == RUN);
      io.done      = (state == DONE);
      io.err_count = err_q;
      io.pass      = (state == DONE) && (err_q == '0);
      io.state     = state;
   end

   // Run configuration capture, hold counter and saturating error count.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_q   <= HOLD_W'(1);
         hold_cnt <= '0;
         check_q  <= 1'b0;
         err_q    <= '0;
      end else if (accept) begin
         hold_q   <= hold_eff;
         hold_cnt <= hold_eff - 1'b1;
         check_q  <= io.check_en;
         err_q    <= '0;
      end else if (state == RUN) begin
         if (sample)
            hold_cnt <= hold_q - 1'b1;
         else
            hold_cnt <= hold_cnt - 1'b1;
         if (mismatch && (err_q != '1))
            err_q <= err_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_scic_io_sequencer.sv
// Bench for scic_io_sequencer: two instances (8-bit and 2-bit error
// counters) share stimulus; each cycle of every run is checked against a
// pattern-table model with cumulative mismatch counting.
module tb_scic_io_sequencer;
  import scic_io_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  scic_io_sequencer_if #(.WIDTH(4), .HOLD_W(8), .ERR_W(8)) if_a ();
  scic_io_sequencer_if #(.WIDTH(4), .HOLD_W(8), .ERR_W(2)) if_b ();

  scic_io_sequencer #(.WIDTH(4), .HOLD_W(8), .ERR_W(8), .LFSR_SEED(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .io    (if_a)
  );

  scic_io_sequencer #(.WIDTH(4), .HOLD_W(8), .ERR_W(2), .LFSR_SEED(1)) dut_b (
    .clock (clock),
    .reset (reset),
    .io    (if_b)
  );

  // LED model: 0 = loopback, 1 = bit 0 stuck low, 2 = all LEDs dead.
  logic [1:0] fault_sel = 2'd0;

  function automatic logic [3:0] fault_fn(input logic [1:0] f, input logic [3:0] s);
    case (f)
      2'd1:    return s & 4'b1110;
      2'd2:    return 4'b0000;
      default: return s;
    endcase
  endfunction

  always_comb if_a.leds = fault_fn(fault_sel, if_a.switches);
  always_comb if_b.leds = fault_fn(fault_sel, if_b.switches);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];
  int seen[16];
  // Maximal-length sequence of x^4+x^3+1 from seed 1, worked out by hand.
  logic [3:0] lfsr_ref[15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                               4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_inputs(input logic s, input logic [1:0] m, input logic [7:0] h, input logic c);
    if_a.start = s; if_a.mode = m; if_a.hold_cycles = h; if_a.check_en = c;
    if_b.start = s; if_b.mode = m; if_b.hold_cycles = h; if_b.check_en = c;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sw_a"},   if_a.switches,  0);
    chk({tag, "_busy_a"}, if_a.busy,      0);
    chk({tag, "_done_a"}, if_a.done,      0);
    chk({tag, "_err_a"},  if_a.err_count, 0);
    chk({tag, "_pass_a"}, if_a.pass,      0);
    chk({tag, "_sw_b"},   if_b.switches,  0);
    chk({tag, "_err_b"},  if_b.err_count, 0);
  endtask

  // One complete run. abort_at >= 0 asserts reset at that cycle of the run;
  // noise scrambles mode/hold/check_en and pokes start while the run is busy.
  task automatic run(input logic [1:0] m, input logic [7:0] hold, input logic c,
                     input logic [1:0] flt, input bit noise, input int abort_at);
    int h;
    int n;
    int err_m;
    logic [3:0] cur;
    h = (hold == 0) ? 1 : int'(hold);
    exp_q.delete();
    if (m == 2'd1) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(4'(1 << i));
    end else if (m == 2'd2) begin
      for (int i = 0; i < 15; i++) exp_q.push_back(lfsr_ref[i]);
    end else begin
      for (int v = 1; v < 16; v++) exp_q.push_back(4'(v));
    end
    n = exp_q.size();
    for (int v = 0; v < 16; v++) seen[v] = 0;
    err_m = 0;
    cur = 4'h0;
    fault_sel = flt;
    set_inputs(1'b1, m, hold, c);
    tick();
    if_a.start = 1'b0; if_b.start = 1'b0;
    for (int j = 0; j < n * h; j++) begin
      if (j == abort_at) begin
        if_a.start = 1'b0; if_b.start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("abort");
        return;
      end
      if (j % h == 0) begin
        if (j > 0 && c && fault_fn(flt, cur) != cur) err_m++;
        cur = exp_q.pop_front();
        seen[if_a.switches]++;
      end
      chk("run_sw_a",   if_a.switches,  cur);
      chk("run_sw_b",   if_b.switches,  cur);
      chk("run_busy",   if_a.busy,      1);
      chk("run_done",   if_a.done,      0);
      chk("run_pass",   if_a.pass,      0);
      chk("run_err_a",  if_a.err_count, err_m);
      chk("run_err_b",  if_b.err_count, (err_m > 3) ? 3 : err_m);
      if (noise) begin
        set_inputs($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      end
      tick();
    end
    if_a.start = 1'b0; if_b.start = 1'b0;
    if (c && fault_fn(flt, cur) != cur) err_m++;
    for (int k = 0; k < 2; k++) begin
      chk("end_sw",     if_a.switches,  0);
      chk("end_busy",   if_a.busy,      0);
      chk("end_done_a", if_a.done,      1);
      chk("end_done_b", if_b.done,      1);
      chk("end_state",  if_a.state,     DONE);
      chk("end_err_a",  if_a.err_count, err_m);
      chk("end_err_b",  if_b.err_count, (err_m > 3) ? 3 : err_m);
      chk("end_pass_a", if_a.pass,      err_m == 0);
      chk("end_pass_b", if_b.pass,      err_m == 0);
      tick();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    set_inputs(1'b0, 2'd0, 8'd1, 1'b0);
    repeat (3) tick();
    check_idle_outputs("reset");
    chk("reset_state", if_a.state, IDLE);
    reset = 1'b0;
    tick();
    check_idle_outputs("idle");

    // loopback count run, hold 6
    run(2'd0, 8'd6, 1'b1, 2'd0, 1'b0, -1);
    // walk with bit 0 stuck low, then count with the same fault
    run(2'd1, 8'd3, 1'b1, 2'd1, 1'b0, -1);
    run(2'd0, 8'd3, 1'b1, 2'd1, 1'b0, -1);
    // LFSR at hold 1: every non-zero value exactly once
    run(2'd2, 8'd1, 1'b1, 2'd0, 1'b0, -1);
    for (int v = 1; v < 16; v++) chk("lfsr_seen", seen[v], 1);
    // dead LEDs saturate the narrow counter; hold 0 acts as hold 1
    run(2'd0, 8'd0, 1'b1, 2'd2, 1'b0, -1);
    // reset at cycle 20 of a count run, then a run with start pokes/noise
    run(2'd0, 8'd2, 1'b1, 2'd2, 1'b0, 20);
    run(2'd0, 8'd2, 1'b1, 2'd1, 1'b1, -1);
    // restart from DONE twice, then check_en=0 with faulty LEDs
    run(2'd1, 8'd2, 1'b1, 2'd1, 1'b0, -1);
    run(2'd1, 8'd2, 1'b1, 2'd1, 1'b0, -1);
    run(2'd0, 8'd1, 1'b0, 2'd1, 1'b0, -1);
    // randomized runs, including the reserved mode
    repeat (8) begin
      run(2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 2)), 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
